// File: rtl/traceback_unit_pkg.sv
// Shared parameters and FSM state type for the Viterbi traceback stage.
package traceback_unit_pkg;

  localparam int ST_W_DEF           = 8;
  localparam int NUM_ST_DEF         = 2 ** ST_W_DEF;
  localparam int TB_DEPTH_DEF       = 32;
  localparam int MAX_TRANSITION_NUM = 2;

  typedef enum logic {
    IDLE,
    TRACE
  } tb_state_t;

endpackage

// File: rtl/traceback_unit_if.sv
// Column input from add_compare_select and decoded-block output of the traceback stage.
interface traceback_unit_if
  import traceback_unit_pkg::*;
#(
  parameter int ST_W     = ST_W_DEF,
  parameter int TB_DEPTH = TB_DEPTH_DEF
);

  localparam int NUM_ST = 2 ** ST_W;

  logic                en_tb;
  logic [ST_W-1:0]     i_fwd_nxt_st [NUM_ST-1:0];
  logic [ST_W-1:0]     i_sel_node;
  logic [TB_DEPTH-1:0] o_dec_data;
  logic                o_dec_valid;
  logic                o_busy;

  modport master (
    output en_tb, i_fwd_nxt_st, i_sel_node,
    input  o_dec_data, o_dec_valid, o_busy
  );

  modport slave (
    input  en_tb, i_fwd_nxt_st, i_sel_node,
    output o_dec_data, o_dec_valid, o_busy
  );

endinterface

// File: rtl/traceback_unit_survivor_mem.sv
// Ping-pong survivor storage: a whole trellis column is written per cycle,
// one predecessor pointer is read combinationally.
module traceback_unit_survivor_mem #(
  parameter  int ST_W     = 8,
  parameter  int TB_DEPTH = 32,
  localparam int NUM_ST   = 2 ** ST_W,
  localparam int IDX_W    = $clog2(TB_DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ST_W-1:0]  wr_col [NUM_ST-1:0],
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [ST_W-1:0]  rd_state,
  output logic [ST_W-1:0]  rd_pred
);

  logic [ST_W-1:0] mem [2][TB_DEPTH][NUM_ST];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int s = 0; s < NUM_ST; s++) begin
        mem[wr_bank][wr_idx][s] <= wr_col[s];
      end
    end
  end

  assign rd_pred = mem[rd_bank][rd_idx][rd_state];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi block traceback: fills one bank of survivor columns while the
// other bank is traced back TB_DEPTH steps from the best end node.
module traceback_unit
  import traceback_unit_pkg::*;
#(
  parameter int ST_W     = ST_W_DEF,
  parameter int TB_DEPTH = TB_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  traceback_unit_if.slave tb_bus
);

  localparam int              NUM_ST = 2 ** ST_W;
  localparam int              IDX_W  = $clog2(TB_DEPTH);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(TB_DEPTH - 1);

  logic [IDX_W-1:0]    wr_idx;
  logic                wr_bank;
  logic                bank_full;

  tb_state_t           state, state_nxt;
  logic [IDX_W-1:0]    k, k_nxt;
  logic [ST_W-1:0]     cur, cur_nxt;
  logic                trace_bank, trace_bank_nxt;
  logic [TB_DEPTH-1:0] dec_buf, dec_buf_nxt;
  logic [TB_DEPTH-1:0] dec_data, dec_data_nxt;
  logic                dec_valid, dec_valid_nxt;
  logic [ST_W-1:0]     rd_pred;

  // bank_full is combinational so the trace can start right after the last write
  assign bank_full = tb_bus.en_tb && (wr_idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (tb_bus.en_tb) begin
      if (wr_idx == LAST) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
    end
  end

  traceback_unit_survivor_mem #(
    .ST_W     (ST_W),
    .TB_DEPTH (TB_DEPTH)
  ) u_survivor_mem (
    .clk      (clk),
    .wr_en    (tb_bus.en_tb),
    .wr_bank  (wr_bank),
    .wr_idx   (wr_idx),
    .wr_col   (tb_bus.i_fwd_nxt_st),
    .rd_bank  (trace_bank),
    .rd_idx   (k),
    .rd_state (cur),
    .rd_pred  (rd_pred)
  );

  always_comb begin
    state_nxt      = state;
    k_nxt          = k;
    cur_nxt        = cur;
    trace_bank_nxt = trace_bank;
    dec_buf_nxt    = dec_buf;
    dec_data_nxt   = dec_data;
    dec_valid_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bank_full) begin
          state_nxt      = TRACE;
          cur_nxt        = tb_bus.i_sel_node;
          k_nxt          = LAST;
          trace_bank_nxt = wr_bank;
        end
      end
      TRACE: begin
        // The state MSB after column k is the bit that entered at column k
        dec_buf_nxt[k] = cur[ST_W-1];
        cur_nxt        = rd_pred;
        k_nxt          = k - IDX_W'(1);
        if (k == '0) begin
          dec_data_nxt  = dec_buf_nxt;
          dec_valid_nxt = 1'b1;
          if (bank_full) begin
            cur_nxt        = tb_bus.i_sel_node;
            k_nxt          = LAST;
            trace_bank_nxt = wr_bank;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      cur        <= '0;
      trace_bank <= 1'b0;
      dec_buf    <= '0;
      dec_data   <= '0;
      dec_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      cur        <= cur_nxt;
      trace_bank <= trace_bank_nxt;
      dec_buf    <= dec_buf_nxt;
      dec_data   <= dec_data_nxt;
      dec_valid  <= dec_valid_nxt;
    end
  end

  assign tb_bus.o_dec_data  = dec_data;
  assign tb_bus.o_dec_valid = dec_valid;
  assign tb_bus.o_busy      = (state == TRACE);

endmodule

// File: tb/tb_traceback_unit.sv
// Scoreboard bench: a small instance (ST_W=2, TB_DEPTH=4) for hand vectors and
// timing, and a default instance fed by a noiseless encoder/ACS model.
module tb_traceback_unit;
  import traceback_unit_pkg::*;

  localparam int SW_S = 2;
  localparam int TD_S = 4;
  localparam int NS_S = 4;
  localparam int SW_B = 8;
  localparam int TD_B = 32;
  localparam int NS_B = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traceback_unit_if #(.ST_W(SW_S), .TB_DEPTH(TD_S)) bus_s ();
  traceback_unit_if #(.ST_W(SW_B), .TB_DEPTH(TD_B)) bus_b ();

  traceback_unit #(.ST_W(SW_S), .TB_DEPTH(TD_S)) dut_s (
    .clk    (clk),
    .rst    (rst),
    .tb_bus (bus_s)
  );

  traceback_unit #(.ST_W(SW_B), .TB_DEPTH(TD_B)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .tb_bus (bus_b)
  );

  int total = 0;
  int bad   = 0;

  logic [TD_S-1:0] q_s [$];
  logic [TD_B-1:0] q_b [$];
  logic [SW_S-1:0] enc_s = '0;
  logic [SW_B-1:0] enc_b = '0;
  logic [TD_S-1:0] blk_s;
  logic [TD_B-1:0] blk_b;
  int              cidx_s;
  int              cidx_b;

  task automatic idle_s();
    bus_s.en_tb = 1'b0;
    for (int s = 0; s < NS_S; s++) bus_s.i_fwd_nxt_st[s] = '0;
    bus_s.i_sel_node = '0;
  endtask

  task automatic idle_b();
    bus_b.en_tb = 1'b0;
    for (int s = 0; s < NS_B; s++) bus_b.i_fwd_nxt_st[s] = '0;
    bus_b.i_sel_node = '0;
  endtask

  // Noiseless ACS: the true next state points at the true previous state,
  // every other state points at one of its two legal predecessors.
  task automatic drive_bit_s(input bit b);
    logic [SW_S-1:0] nxt;
    logic [SW_S-1:0] st;
    nxt = {b, enc_s[SW_S-1:1]};
    for (int s = 0; s < NS_S; s++) begin
      st = SW_S'(s);
      bus_s.i_fwd_nxt_st[s] = {st[SW_S-2:0], 1'b0};
    end
    bus_s.i_fwd_nxt_st[nxt] = enc_s;
    enc_s = nxt;
    bus_s.en_tb = 1'b1;
    bus_s.i_sel_node = nxt;
    blk_s[cidx_s] = b;
    if (cidx_s == TD_S - 1) begin
      q_s.push_back(blk_s);
      cidx_s = 0;
    end else begin
      cidx_s++;
    end
  endtask

  task automatic drive_bit_b(input bit b);
    logic [SW_B-1:0] nxt;
    logic [SW_B-1:0] st;
    nxt = {b, enc_b[SW_B-1:1]};
    for (int s = 0; s < NS_B; s++) begin
      st = SW_B'(s);
      bus_b.i_fwd_nxt_st[s] = {st[SW_B-2:0], 1'b0};
    end
    bus_b.i_fwd_nxt_st[nxt] = enc_b;
    enc_b = nxt;
    bus_b.en_tb = 1'b1;
    bus_b.i_sel_node = nxt;
    blk_b[cidx_b] = b;
    if (cidx_b == TD_B - 1) begin
      q_b.push_back(blk_b);
      cidx_b = 0;
    end else begin
      cidx_b++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_s();
    idle_b();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cidx_s = 0;
    cidx_b = 0;
    q_s.delete();
    q_b.delete();
  endtask

  task automatic wait_valid_s(input int budget, output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      bus_s.en_tb = 1'b0;
      if (bus_s.o_dec_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    int waited;
    do_reset();
    @(negedge clk);
    total++;
    if (bus_s.o_dec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus_s.o_dec_valid); end
    total++;
    if (bus_s.o_dec_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus_s.o_dec_data); end
    total++;
    if (bus_s.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_s.o_busy); end
    total++;
    if ({bus_b.o_dec_valid, bus_b.o_busy, bus_b.o_dec_data} !== '0) begin
      bad++; $display("FAIL reset_big: got v=%b b=%b d=%h want all 0", bus_b.o_dec_valid, bus_b.o_busy, bus_b.o_dec_data);
    end
    // partial bank then reset: no pulse may follow
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_bit_s(1'($urandom_range(1)));
    end
    do_reset();
    wait_valid_s(12, got, waited);
    total++;
    if (got !== 1'b0) begin bad++; $display("FAIL reset_partial_pulse: got %b want 0", got); end
    // reset in the middle of a trace
    for (int i = 0; i < TD_S; i++) begin
      @(negedge clk);
      drive_bit_s(1'($urandom_range(1)));
    end
    @(negedge clk);
    idle_s();
    @(negedge clk);
    total++;
    if (bus_s.o_busy !== 1'b1) begin bad++; $display("FAIL midtrace_busy: got %b want 1", bus_s.o_busy); end
    do_reset();
    @(negedge clk);
    total++;
    if (bus_s.o_busy !== 1'b0) begin bad++; $display("FAIL midtrace_reset_busy: got %b want 0", bus_s.o_busy); end
    wait_valid_s(12, got, waited);
    total++;
    if (got !== 1'b0) begin bad++; $display("FAIL midtrace_reset_pulse: got %b want 0", got); end
  endtask

  task automatic test_vector();
    logic [SW_S-1:0] vc [TD_S][NS_S];
    logic [TD_S-1:0] exp_d;
    bit got;
    int waited;
    do_reset();
    for (int c = 0; c < TD_S; c++)
      for (int s = 0; s < NS_S; s++) vc[c][s] = '0;
    vc[0][2] = 2'b00;
    vc[1][1] = 2'b10;
    vc[2][2] = 2'b01;
    vc[3][3] = 2'b10;
    q_s.push_back(4'b1101);
    for (int c = 0; c < TD_S; c++) begin
      @(negedge clk);
      bus_s.en_tb = 1'b1;
      for (int s = 0; s < NS_S; s++) bus_s.i_fwd_nxt_st[s] = vc[c][s];
      bus_s.i_sel_node = (c == TD_S - 1) ? 2'b11 : 2'b00;
    end
    wait_valid_s(TD_S + 6, got, waited);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL vector_pulse: got %b want 1", got); end
    total++;
    if (waited != TD_S + 1) begin bad++; $display("FAIL vector_latency: got %0d want %0d", waited, TD_S + 1); end
    exp_d = q_s.pop_front();
    total++;
    if (bus_s.o_dec_data !== exp_d) begin bad++; $display("FAIL vector_data: got %b want %b", bus_s.o_dec_data, exp_d); end
    @(negedge clk);
    total++;
    if ({bus_s.o_dec_valid, bus_s.o_dec_data} !== {1'b0, exp_d}) begin
      bad++; $display("FAIL vector_hold: got v=%b d=%b want v=0 d=%b", bus_s.o_dec_valid, bus_s.o_dec_data, exp_d);
    end
  endtask

  task automatic test_zero();
    logic [TD_S-1:0] exp_d;
    logic [SW_S-1:0] sel_list [2];
    bit got;
    int waited;
    do_reset();
    sel_list[0] = 2'b10;
    sel_list[1] = 2'b00;
    for (int r = 0; r < 2; r++) begin
      q_s.push_back((r == 0) ? 4'b1000 : 4'b0000);
      for (int c = 0; c < TD_S; c++) begin
        @(negedge clk);
        bus_s.en_tb = 1'b1;
        for (int s = 0; s < NS_S; s++) bus_s.i_fwd_nxt_st[s] = '0;
        bus_s.i_sel_node = sel_list[r];
      end
      wait_valid_s(TD_S + 6, got, waited);
      total++;
      if (got !== 1'b1) begin bad++; $display("FAIL zero_pulse%0d: got %b want 1", r, got); end
      exp_d = q_s.pop_front();
      total++;
      if (bus_s.o_dec_data !== exp_d) begin bad++; $display("FAIL zero_data%0d: got %b want %b", r, bus_s.o_dec_data, exp_d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [TD_S-1:0] exp_d;
    bit exp_busy;
    bit exp_valid;
    do_reset();
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      exp_busy  = (j >= 4 && j <= 11);
      exp_valid = (j == 8 || j == 12);
      total++;
      if (bus_s.o_busy !== exp_busy) begin bad++; $display("FAIL b2b_busy@%0d: got %b want %b", j, bus_s.o_busy, exp_busy); end
      total++;
      if (bus_s.o_dec_valid !== exp_valid) begin bad++; $display("FAIL b2b_valid@%0d: got %b want %b", j, bus_s.o_dec_valid, exp_valid); end
      if (bus_s.o_dec_valid === 1'b1 && q_s.size() > 0) begin
        exp_d = q_s.pop_front();
        total++;
        if (bus_s.o_dec_data !== exp_d) begin bad++; $display("FAIL b2b_data@%0d: got %b want %b", j, bus_s.o_dec_data, exp_d); end
      end
      if (j < 8) drive_bit_s(1'($urandom_range(1)));
      else bus_s.en_tb = 1'b0;
    end
    total++;
    if (q_s.size() != 0) begin bad++; $display("FAIL b2b_leftover: got %0d want 0", q_s.size()); end
  endtask

  task automatic test_gapped();
    logic [TD_S-1:0] exp_d;
    int ncol;
    int last4;
    int pulses;
    int first_pulse;
    do_reset();
    ncol = 0;
    last4 = -1;
    pulses = 0;
    first_pulse = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (bus_s.o_dec_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = j;
        total++;
        if (q_s.size() == 0) begin
          bad++; $display("FAIL gap_unexpected_pulse@%0d: got pulse want none", j);
        end else begin
          exp_d = q_s.pop_front();
          if (bus_s.o_dec_data !== exp_d) begin bad++; $display("FAIL gap_data@%0d: got %b want %b", j, bus_s.o_dec_data, exp_d); end
        end
      end
      if (j % 2 == 0 && ncol < 2 * TD_S) begin
        drive_bit_s(1'($urandom_range(1)));
        ncol++;
        if (ncol == TD_S) last4 = j;
      end else begin
        bus_s.en_tb = 1'b0;
      end
    end
    total++;
    if (first_pulse != last4 + TD_S + 1) begin bad++; $display("FAIL gap_latency: got %0d want %0d", first_pulse, last4 + TD_S + 1); end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL gap_pulse_count: got %0d want 2", pulses); end
  endtask

  task automatic test_random_default();
    logic [TD_B-1:0] exp_d;
    int ncol;
    int pulses;
    do_reset();
    ncol = 0;
    pulses = 0;
    for (int j = 0; j < 400 && pulses < 4; j++) begin
      @(negedge clk);
      if (bus_b.o_dec_valid === 1'b1) begin
        pulses++;
        total++;
        if (q_b.size() == 0) begin
          bad++; $display("FAIL rand_unexpected_pulse@%0d: got pulse want none", j);
        end else begin
          exp_d = q_b.pop_front();
          if (bus_b.o_dec_data !== exp_d) begin bad++; $display("FAIL rand_data%0d: got %h want %h", pulses, bus_b.o_dec_data, exp_d); end
        end
      end
      if (ncol < 4 * TD_B && $urandom_range(3) != 0) begin
        drive_bit_b(1'($urandom_range(1)));
        ncol++;
      end else begin
        bus_b.en_tb = 1'b0;
      end
    end
    total++;
    if (pulses != 4) begin bad++; $display("FAIL rand_pulse_count: got %0d want 4", pulses); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_s();
    idle_b();
    test_reset();
    test_vector();
    test_zero();
    test_back_to_back();
    test_gapped();
    test_random_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
Viterbi survivor-path traceback stage that sits directly downstream of add_compare_select. Every enabled cycle it stores one trellis column of per-state predecessor pointers together with the best end node for that column. Survivor storage is two ping-pong banks of TB_DEPTH columns each. When a bank fills, the block traces back TB_DEPTH steps from the best node and emits the decoded block in parallel.

Parameters:
ST_W, 8, state width in bits (the shift register of the convolutional encoder).
NUM_ST, 2**ST_W = 256, number of trellis states; a derived localparam, not overridable.
TB_DEPTH, 32, columns per bank, which is also the number of decoded bits per output block.

Ports:
clk  input  1  single clock; all logic on the rising edge
rst  input  1  reset, synchronous and active-high
en_tb  input  1  column valid; qualifies i_fwd_nxt_st and i_sel_node
i_fwd_nxt_st  input  NUM_ST x ST_W (unpacked array [NUM_ST-1:0])  entry s = predecessor of state s for this column
i_sel_node  input  ST_W  best (minimum-metric) state after this column
o_dec_data  output  TB_DEPTH  decoded bits; bit k = bit decoded from column k of the bank, bit 0 = oldest column
o_dec_valid  output  1  one-cycle pulse; o_dec_data is valid in that cycle
o_busy  output  1  high while the FSM is in TRACE

Behaviour:
- Reset, synchronous: when rst=1 at a clock edge,
  - wr_idx=0, wr_bank=0, FSM=IDLE;
  - o_dec_valid=0, o_dec_data=0, o_busy=0;
  - survivor memory contents are not cleared (don't care).
  - Reset mid-fill or mid-trace discards the partial bank and any trace in progress; no o_dec_valid is produced for it.
- Write path: on each cycle with en_tb=1,
  - store i_fwd_nxt_st into mem[wr_bank][wr_idx];
  - increment wr_idx.
  - When wr_idx==TB_DEPTH-1 (last column of the bank), also:
    - latch i_sel_node into start_node;
    - wrap wr_idx to 0 and toggle wr_bank;
    - raise bank_full for one cycle, tagging the completed bank.
  - If en_tb=0, nothing changes.
- Trellis convention: the new input bit enters the state MSB, so next_state = {in, cur[ST_W-1:1]}. The decoded bit of column k is therefore bit ST_W-1 of the state after column k.
- FSM states:
  - IDLE: on bank_full, set cur=start_node and k=TB_DEPTH-1, then go to TRACE.
  - TRACE: one step per cycle:
    - dec_buf[k] = cur[ST_W-1];
    - cur = mem[trace_bank][k][cur] (combinational read of the array);
    - k decrements.
    - After the k=0 step, register o_dec_data=dec_buf (with the final bit) and pulse o_dec_valid=1 on the next cycle.
    - If bank_full arrives on that same final step, restart TRACE directly on the new bank with no IDLE cycle. Otherwise return to IDLE.
- Latency: if the last write of a bank happens at cycle N, TRACE occupies cycles N+1 through N+TB_DEPTH, and o_dec_valid=1 at cycle N+TB_DEPTH+1.
- Throughput: filling a bank takes at least TB_DEPTH cycles and a trace takes exactly TB_DEPTH cycles.
  - Therefore at full rate (en_tb held high) the bank being traced is never overwritten, and no overrun is possible.
  - bank_full can only coincide with the final TRACE step, never an earlier one.
- Block traceback uses no overlap. o_busy=1 exactly in TRACE cycles. o_dec_data holds its value between pulses.

Decomposition:
- Shared package (param_def):
  - ST_W, NUM_ST and TB_DEPTH defaults, next to MAX_TRANSITION_NUM;
  - the tb_state_t enum {IDLE, TRACE}.
- One sub-module, survivor_mem:
  - two banks of TB_DEPTH x NUM_ST x ST_W;
  - one write port (bank, idx, column);
  - one combinational read port (bank, idx, state) returning ST_W bits.
- FSM, counters and output registers stay in traceback_unit.

Test Plan:
- Reset: rst=1 for 2 cycles at any point -> o_dec_valid=0, o_dec_data=0, o_busy=0; a partial bank followed by rst produces no pulse.
- ST_W=2, TB_DEPTH=4, encoded inputs 1,0,1,1:
  - columns: col0[2'b10]=2'b00, col1[2'b01]=2'b10, col2[2'b10]=2'b01, col3[2'b11]=2'b10, all other entries 0;
  - i_sel_node=2'b11 on the last column;
  - -> o_dec_data=4'b1101.
- All-zero predecessors with i_sel_node=0 -> o_dec_data=0. Repeat with i_sel_node=2'b10 -> only bit 3 is set (4'b1000).
- Timing, TB_DEPTH=4, en_tb high on cycles 0..7 -> o_busy high on 4..11; o_dec_valid pulses at cycles 8 and 12 with no IDLE gap between the two traces.
- Gapped input, en_tb toggling 1/0 -> the pulse comes TB_DEPTH+1 cycles after the 4th valid column. No columns are lost across the bank switch.
- Default parameters (ST_W=8, TB_DEPTH=32), random encoder bit stream, noiseless ACS model -> each o_dec_data equals the 32 source bits in order.
